// File: rtl/stack_pkg.sv
// rtl/stack_pkg.sv - shared sizing constants for the hardware data stack
package stack_pkg;

    localparam int STACK_WIDTH = 8;
    localparam int STACK_DEPTH = 16;
    localparam int STACK_CW    = $clog2(STACK_DEPTH) + 1;

endpackage : stack_pkg

// File: rtl/stack_mem.sv
// rtl/stack_mem.sv - stack entry array, synchronous write, combinational read
module stack_mem
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Entries are not reset; only the counter decides which ones are valid.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule : stack_mem

// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - LIFO data stack feeding the register-file write mux
module stack_unit
    import stack_pkg::*;
#(
    parameter int WIDTH = STACK_WIDTH,
    parameter int DEPTH = STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf,
    output logic                       unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_unf;

    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_top_addr;
    logic [AW-1:0]    w_waddr;
    logic             w_we;
    logic [CW-1:0]    w_count_next;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic [WIDTH-1:0] w_rdata;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_COUNT);
    // When full the low bits wrap to zero, so minus one still lands on DEPTH-1.
    assign w_top_addr = r_count[AW-1:0] - AW'(1);

    // Push+pop on a non-empty stack overwrites the top; otherwise write above it.
    // A pushing write is dropped only for a lone push on a full stack.
    always_comb begin
        w_we         = 1'b0;
        w_waddr      = r_count[AW-1:0];
        w_count_next = r_count;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        if (push && pop) begin
            w_we = 1'b1;
            if (w_empty) begin
                w_count_next = CW'(1);
                w_set_unf    = 1'b1;
            end else begin
                w_waddr = w_top_addr;
            end
        end else if (push) begin
            if (w_full) begin
                w_set_ovf = 1'b1;
            end else begin
                w_we         = 1'b1;
                w_count_next = r_count + CW'(1);
            end
        end else if (pop) begin
            if (w_empty) begin
                w_set_unf = 1'b1;
            end else begin
                w_count_next = r_count - CW'(1);
            end
        end
        if (clr) begin
            w_we = 1'b0;
        end
    end

    // Counter and sticky flags; clr wins over any push/pop in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_ovf   <= r_ovf | w_set_ovf;
            r_unf   <= r_unf | w_set_unf;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (w_we),
        .waddr (w_waddr),
        .wdata (din),
        .raddr (w_top_addr),
        .rdata (w_rdata)
    );

    assign dout  = w_empty ? '0 : w_rdata;
    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule : stack_unit

// File: doc/stack_unit.md
# stack_unit

Hardware LIFO data stack for the single-cycle processor. It supplies the `stack` input of the datapath's register-file write-data multiplexer, so PUSH/POP instructions can move 8-bit values between the register file and a private stack in one instruction. The control unit drives `push`/`pop` from the opcode. The value pushed comes from the register file's second read port. `dout` is the top-of-stack value that a POP writes back to the register file in the same cycle.

## Interface
- `WIDTH`, default 8: data width; matches the register-file word.
- `DEPTH`, default 16: number of entries; power of two, ≥ 2.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state immediately.
- `clr`  in  1: synchronous clear, highest priority.
- `push`  in  1: push `din` this cycle.
- `pop`  in  1: pop the top entry this cycle.
- `din`  in  WIDTH: data to push (register-file RD2).
- `dout`  out  WIDTH: current top of stack; 0 when empty.
- `count`  out  $clog2(DEPTH)+1: number of valid entries, 0..DEPTH.
- `empty`  out  1: count == 0.
- `full`  out  1: count == DEPTH.
- `ovf`  out  1: sticky overflow, set by a push that is dropped.
- `unf`  out  1: sticky underflow, set by a pop on an empty stack.

## Operation
- **State:**
  - entry array `mem[0..DEPTH-1]`.
  - counter `count`, which also acts as the stack pointer; the top entry is `mem[count-1]`.
  - flags `ovf`/`unf`.
- **Reset** (while `reset` = 0): count = 0, ovf = 0, unf = 0. Outputs: dout = 0, empty = 1, full = 0. Array contents are don't-care; they are not cleared.
- **Per-edge priority:** `clr` first, then the push/pop cases below.
- `clr`=1: count ← 0, ovf ← 0, unf ← 0; push and pop are ignored.
- **Push only:**
  - not full: mem[count] ← din, count ← count+1.
  - full: no change except ovf ← 1.
- **Pop only:**
  - not empty: count ← count−1. The popped data is the `dout` presented before the edge.
  - empty: no change except unf ← 1.
- **Push and pop together:**
  - count > 0 (including full): replace the top, mem[count-1] ← din; count unchanged; no flag set.
  - count = 0: din is pushed (count ← 1) and unf ← 1.
- **Idle:** no change.
- **Flags:** ovf and unf clear only on `reset` or `clr`; they never self-clear.
- **Output decode:** `dout` = mem[count-1] when count > 0, else all zeros. `empty` and `full` are combinational decodes of `count`.

## Timing
- Zero read latency: `dout`, `empty` and `full` reflect the state after the most recent edge. A POP instruction therefore captures `dout` into the register file at the same edge that decrements `count`.
- Write latency is one edge: a value pushed at edge N appears on `dout` after edge N.
- Back-to-back push/pop on consecutive cycles needs no bubbles.
- Asserting `reset` mid-operation forces the reset values asynchronously. State resumes from empty at the first edge after `reset` deasserts.
- Counter arithmetic is unsigned and never wraps. Both saturating cases (push when full, pop when empty) are blocked and flagged instead.

## Structure
- Shared package `stack_pkg`: `STACK_WIDTH` = 8, `STACK_DEPTH` = 16, and a derived `STACK_CW` = $clog2(STACK_DEPTH)+1. The control unit and the datapath use the same constants.
- Natural sub-module `stack_mem`: DEPTH×WIDTH array with a synchronous write port (we, waddr, wdata) and a combinational read port (raddr, rdata).
- `stack_unit` holds the counter, the flag logic, the address select (write address = count or count-1) and the empty-masking of `dout`.
- Expected size: about 150–200 RTL lines total.

## Test plan
- **Reset:** hold reset low, then release → count=0, empty=1, full=0, dout=0x00, ovf=unf=0. Then push 0xA5 → dout=0xA5, count=1.
- **Fill and overflow:** push 0x01..0x10 (16 values) → full=1, dout=0x10. Push 0xFF → count stays 16, dout=0x10, ovf=1.
- **Drain and underflow:** from the full stack, pop 16 times → dout sequence 0x10, 0x0F, …, 0x01 sampled before each edge; then empty=1, dout=0x00. Pop once more → unf=1, count=0.
- **Simultaneous push and pop:**
  - stack [0x11, 0x22 on top], push+pop with din=0x33 → count=2, dout=0x33; after one pop, dout=0x11.
  - on an empty stack, push+pop with din=0x44 → count=1, dout=0x44, unf=1.
- **Clear precedence:** flags set and count=5, then clr with push asserted → count=0, ovf=unf=0, nothing pushed.
- **Asynchronous reset mid-stream:** drop reset between edges while count=7 → outputs reach reset values before the next edge. Release reset and push 0x5A → count=1, dout=0x5A.
